// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions used by the fetch and operand-fetch stages.
// Holds the opcode field layout, special opcodes and the fetch FSM state type.
package simplerisc_pkg;

  localparam int XLEN = 32;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;

  localparam logic [4:0] OPC_HLT = 5'b11111;
  localparam logic [4:0] OPC_NOP = 5'b01101;

  localparam logic [XLEN-1:0] NOP_INST = {OPC_NOP, 27'b0};

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  function automatic logic is_halt(input logic [XLEN-1:0] inst);
    return inst[OPC_MSB:OPC_LSB] == OPC_HLT;
  endfunction

endpackage

// File: rtl/fetch_unit_if_of_latch.sv
// IF/OF pipeline latch: an enable register for {pc, inst, valid}.
// Flushes are done by the caller loading a bubble with the enable asserted.
module if_of_latch
  import simplerisc_pkg::*;
#(
  parameter logic [31:0] RESET_INST = 32'h6800_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic            valid_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (en) begin
      pc_d    = pc_i;
      inst_d  = inst_i;
      valid_d = valid_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      inst_q  <= RESET_INST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// SimpleRISC instruction-fetch stage: owns the PC, drives instruction memory
// and feeds the IF/OF latch, handling stall, branch redirect and halt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h6800_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  output logic [31:0] of_pc,
  output logic [31:0] of_inst,
  output logic        of_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  import simplerisc_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] count_q, count_d;

  logic            latch_en;
  logic [XLEN-1:0] latch_pc;
  logic [XLEN-1:0] latch_inst;
  logic            latch_valid;

  // Priority in RUN is branch > stall > halt > normal; a branch squashes the
  // fetched word, so a halt fetched alongside a redirect never takes effect.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    count_d     = count_q;
    latch_en    = 1'b0;
    latch_pc    = pc_q;
    latch_inst  = imem_rdata;
    latch_valid = 1'b1;

    case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          pc_d        = branch_pc;
          latch_en    = 1'b1;
          latch_inst  = NOP_INST;
          latch_valid = 1'b0;
        end else if (!stall) begin
          latch_en = 1'b1;
          count_d  = count_q + 32'd1;
          if (is_halt(imem_rdata)) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      ST_HALT: begin
        if (!stall) begin
          latch_en    = 1'b1;
          latch_inst  = NOP_INST;
          latch_valid = 1'b0;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  if_of_latch #(
    .RESET_INST(NOP_INST)
  ) u_latch (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (latch_en),
    .pc_i    (latch_pc),
    .inst_i  (latch_inst),
    .valid_i (latch_valid),
    .pc_o    (of_pc),
    .inst_o  (of_inst),
    .valid_o (of_valid)
  );

  assign imem_addr   = pc_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h6800_0000;
  localparam logic [31:0] HLT  = 32'hF800_0000;

  logic        clk;
  logic        rst_n, rst_n2;
  logic        stall, branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] of_pc, of_inst, fetch_count;
  logic        of_valid, halted;

  logic [31:0] imem_addr2, of_pc2, of_inst2, fetch_count2;
  logic        of_valid2, halted2;
  logic [31:0] imem_rdata2;

  logic        haltEn;
  logic [31:0] haltAddr;

  int errors;
  int checks;

  typedef struct {
    string       name;
    bit          sel;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        hlt;
    logic [31:0] cnt;
  } exp_t;

  exp_t expQ[$];
  exp_t e;

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_pc    (branch_pc),
    .of_pc        (of_pc),
    .of_inst      (of_inst),
    .of_valid     (of_valid),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk          (clk),
    .rst_n        (rst_n2),
    .imem_addr    (imem_addr2),
    .imem_rdata   (imem_rdata2),
    .stall        (1'b0),
    .branch_taken (1'b0),
    .branch_pc    (32'h0),
    .of_pc        (of_pc2),
    .of_inst      (of_inst2),
    .of_valid     (of_valid2),
    .halted       (halted2),
    .fetch_count  (fetch_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: all zeros, optionally a halt word at haltAddr.
  always_comb imem_rdata = (haltEn && imem_addr == haltAddr) ? HLT : 32'h0;
  assign imem_rdata2 = 32'h0;

  task automatic checkOutput(input string name, input string field,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %h expected %h", name, field, act, exp);
    end
  endtask

  task automatic pushExp(input string name, input bit sel,
                         input logic [31:0] addr, input logic [31:0] pc,
                         input logic [31:0] inst, input logic valid,
                         input logic hlt, input logic [31:0] cnt);
    exp_t x;
    x.name = name; x.sel = sel; x.addr = addr; x.pc = pc;
    x.inst = inst; x.valid = valid; x.hlt = hlt; x.cnt = cnt;
    expQ.push_back(x);
  endtask

  // Drive inputs, take one rising edge, then record the expected outputs.
  task automatic applyStimulus(input logic st, input logic br,
                               input logic [31:0] bpc, input string name,
                               input bit sel, input logic [31:0] addr,
                               input logic [31:0] pc, input logic [31:0] inst,
                               input logic valid, input logic hlt,
                               input logic [31:0] cnt);
    stall        = st;
    branch_taken = br;
    branch_pc    = bpc;
    @(posedge clk);
    #1;
    pushExp(name, sel, addr, pc, inst, valid, hlt, cnt);
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (!e.sel) begin
        checkOutput(e.name, "imem_addr", imem_addr, e.addr);
        checkOutput(e.name, "of_pc", of_pc, e.pc);
        checkOutput(e.name, "of_inst", of_inst, e.inst);
        checkOutput(e.name, "of_valid", {31'b0, of_valid}, {31'b0, e.valid});
        checkOutput(e.name, "halted", {31'b0, halted}, {31'b0, e.hlt});
        checkOutput(e.name, "fetch_count", fetch_count, e.cnt);
      end else begin
        checkOutput(e.name, "imem_addr", imem_addr2, e.addr);
        checkOutput(e.name, "of_pc", of_pc2, e.pc);
        checkOutput(e.name, "of_inst", of_inst2, e.inst);
        checkOutput(e.name, "of_valid", {31'b0, of_valid2}, {31'b0, e.valid});
        checkOutput(e.name, "halted", {31'b0, halted2}, {31'b0, e.hlt});
        checkOutput(e.name, "fetch_count", fetch_count2, e.cnt);
      end
    end
  end

  initial begin
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b0;
    rst_n2       = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    branch_pc    = 32'h0;
    haltEn       = 1'b0;
    haltAddr     = 32'h20;
    #1;
    pushExp("reset", 1'b0, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 0, 32'h0, "run1",   0, 32'h4,   32'h0,   32'h0, 1, 0, 32'd1);
    applyStimulus(0, 0, 32'h0, "run2",   0, 32'h8,   32'h4,   32'h0, 1, 0, 32'd2);
    applyStimulus(1, 0, 32'h0, "stall1", 0, 32'h8,   32'h4,   32'h0, 1, 0, 32'd2);
    applyStimulus(1, 0, 32'h0, "stall2", 0, 32'h8,   32'h4,   32'h0, 1, 0, 32'd2);
    applyStimulus(0, 0, 32'h0, "resume", 0, 32'hC,   32'h8,   32'h0, 1, 0, 32'd3);
    applyStimulus(0, 0, 32'h0, "run4",   0, 32'h10,  32'hC,   32'h0, 1, 0, 32'd4);
    applyStimulus(1, 1, 32'h100, "brStall", 0, 32'h100, 32'h10, NOP, 0, 0, 32'd4);
    applyStimulus(0, 0, 32'h0, "brTgt",  0, 32'h104, 32'h100, 32'h0, 1, 0, 32'd5);
    applyStimulus(0, 1, 32'h20, "br2",   0, 32'h20,  32'h104, NOP,   0, 0, 32'd5);
    haltEn = 1'b1;
    applyStimulus(0, 1, 32'h40, "brHalt", 0, 32'h40, 32'h20,  NOP,   0, 0, 32'd5);
    applyStimulus(0, 1, 32'h20, "br3",   0, 32'h20,  32'h40,  NOP,   0, 0, 32'd5);
    applyStimulus(0, 0, 32'h0, "halt",   0, 32'h20,  32'h20,  HLT,   1, 1, 32'd6);
    applyStimulus(1, 0, 32'h0, "hStall", 0, 32'h20,  32'h20,  HLT,   1, 1, 32'd6);
    applyStimulus(0, 0, 32'h0, "hBub",   0, 32'h20,  32'h20,  NOP,   0, 1, 32'd6);
    applyStimulus(0, 1, 32'h300, "hBr",  0, 32'h20,  32'h20,  NOP,   0, 1, 32'd6);
    branch_taken = 1'b0;

    // Reset lands between edges; the monitor samples before the next edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    pushExp("asyncRst", 1'b0, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    @(posedge clk);
    #1;
    pushExp("wrapRst", 1'b1, 32'hFFFF_FFFC, 32'h0, NOP, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n2 = 1'b1;
    applyStimulus(0, 0, 32'h0, "wrap1", 1, 32'h0, 32'hFFFF_FFFC, 32'h0, 1, 0, 32'd1);
    applyStimulus(0, 0, 32'h0, "wrap2", 1, 32'h4, 32'h0,         32'h0, 1, 0, 32'd2);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the SimpleRISC five-stage pipeline, sitting directly upstream of the operand-fetch stage. Owns the program counter, drives the instruction-memory address, and loads the IF/OF pipeline latch (`pc`, `inst`, valid) that operand fetch consumes. Handles stall hold, taken-branch redirect with bubble insertion, and halt-instruction detection, after which fetch freezes until reset.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INST`, 32'h6800_0000, encoding injected into the latch as a bubble (nop opcode 01101).

Ports:
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_addr`  out  32  fetch address; equals current PC combinationally.
- `imem_rdata`  in  32  instruction at `imem_addr`; combinational read, valid the same cycle.
- `stall`  in  1  hazard stall from the interlock logic; hold PC and latch.
- `branch_taken`  in  1  taken-branch/jump/ret resolved downstream.
- `branch_pc`  in  32  redirect target, sampled when `branch_taken`=1.
- `of_pc`  out  32  IF/OF latch: PC of the latched instruction.
- `of_inst`  out  32  IF/OF latch: instruction word.
- `of_valid`  out  1  IF/OF latch holds a real instruction (0 = bubble).
- `halted`  out  1  fetch is frozen after a halt instruction.
- `fetch_count`  out  32  number of instructions written into the latch with `of_valid`=1.

## Operation
- States: RUN, HALT. Reset enters RUN.
- Reset (`rst_n`=0, immediate): `pc`=RESET_PC, `of_pc`=0, `of_inst`=NOP_INST, `of_valid`=0, `halted`=0, `fetch_count`=0, state RUN. Reset mid-operation discards all in-flight state.
- Per-edge priority in RUN: `branch_taken` > `stall` > halt detect > normal.
  - branch_taken: `pc`←`branch_pc`; latch ← {`of_pc`=pc, NOP_INST, valid 0}; count unchanged. Branch overrides a simultaneous stall and cancels a simultaneous halt detect.
  - stall: `pc`, latch, count all hold.
  - halt detect (`imem_rdata[31:27]`=5'b11111): latch ← {pc, imem_rdata, valid 1}; count+1; `pc` holds; state→HALT.
  - normal: latch ← {pc, imem_rdata, valid 1}; `pc`←pc+4; count+1.
- HALT: `halted`=1; `pc` holds. If `stall`=1, latch holds; else latch ← {pc, NOP_INST, valid 0}. `branch_taken` ignored. Only reset exits HALT.
- Arithmetic: pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0); `fetch_count` wraps modulo 2^32. `branch_pc` used as given, no alignment check.

## Timing
- `imem_addr` = `pc`, zero-latency combinational.
- Fetch-to-latch latency: 1 cycle; instruction presented in cycle N is on `of_*` after edge N.
- Branch penalty as seen here: 1 bubble; target instruction appears on `of_inst` 2 edges after `branch_taken` sampled.
- `halted` asserts after the edge that latches the halt instruction, together with it on `of_*`.
- All outputs registered except `imem_addr`.

## Structure
- Shared package `simplerisc_pkg`: `XLEN`=32, `OPC_HLT`=5'b11111, `OPC_NOP`=5'b01101, `NOP_INST`, opcode field slice constants [31:27]; consumed also by operand fetch.
- One sub-module natural: `if_of_latch` (enable/flush register for {pc, inst, valid}, async active-low reset); PC/state logic stays in `fetch_unit`.

## Test plan
- Reset, free-run with memory word = 32'h0 at every address: `imem_addr` 0,4,8; after 3 edges `of_pc`=8, `of_valid`=1, `fetch_count`=3.
- `stall`=1 for 2 cycles at pc=8: `imem_addr`, `of_pc`=4, `of_inst`, `fetch_count` unchanged; resume fetches 8.
- `branch_taken`=1, `branch_pc`=32'h100 at pc=0x10 with `stall`=1: next edge `of_valid`=0, `of_inst`=32'h6800_0000, pc=0x100; following edge `of_pc`=0x100, valid 1.
- Halt word 32'hF800_0000 at 0x20: edge latches it (valid 1, `halted`=1), pc stays 0x20; next edges `of_valid`=0 NOP; `branch_taken`=1 afterwards leaves pc=0x20.
- Halt word fetched same cycle as `branch_taken` to 0x40: no halt, `halted`=0, pc=0x40, bubble latched.
- Assert `rst_n`=0 mid-HALT asynchronously between edges: outputs return to reset values immediately; `RESET_PC`=32'hFFFF_FFFC run wraps pc to 0.
